// File: rtl/jtag_access_scheduler.sv
// Round-robin scheduler between the JTAG register bank and fabric logic: host writes become events,
// fabric updates land in the readback bank. Optional sticky overrun flags under JTAG_SCHED_OVERRUN_EN.
module jtag_access_scheduler #(
  parameter int REGISTER_SIZE       = 32,
  parameter int NUMBER_OF_REGISTERS = 4,
  parameter int INDEX_WIDTH         = (NUMBER_OF_REGISTERS > 1) ? $clog2(NUMBER_OF_REGISTERS) : 1
) (
  input  logic                                               iMAIN_CLK,
  input  logic                                               iRESET_N,
  input  logic [NUMBER_OF_REGISTERS-1:0][REGISTER_SIZE-1:0]  iJTAG_DATA,
  output logic [NUMBER_OF_REGISTERS-1:0][REGISTER_SIZE-1:0]  oJTAG_DATA,
  output logic                                               oEV_VALID,
  input  logic                                               iEV_READY,
  output logic [INDEX_WIDTH-1:0]                             oEV_INDEX,
  output logic [REGISTER_SIZE-1:0]                           oEV_DATA,
  input  logic                                               iUP_VALID,
  output logic                                               oUP_READY,
  input  logic [INDEX_WIDTH-1:0]                             iUP_INDEX,
  input  logic [REGISTER_SIZE-1:0]                           iUP_DATA,
  output logic [NUMBER_OF_REGISTERS-1:0]                     oOVERRUN,
  input  logic                                               iOVERRUN_CLR
);

  localparam int N  = NUMBER_OF_REGISTERS;
  localparam int RS = REGISTER_SIZE;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {PRIME, SCAN, PRESENT} state_t;

  state_t              state, state_nxt;
  logic [N-1:0][RS-1:0] snap, prev;
  logic [N-1:0]        pending, changed, clr_mask;
  logic [AW-1:0]       ptr, ptr_nxt, sel_idx, up_addr;
  logic                sel_found, take;

  always_comb begin
    changed = '0;
    for (int i = 0; i < N; i++) begin
      changed[i] = (state != PRIME) && (snap[i] != prev[i]);
    end
  end

  // First pending index at or after ptr, wrapping at N-1 -> 0.
  always_comb begin
    int j;
    logic [AW-1:0] j_idx;
    j         = 0;
    j_idx     = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      j_idx = AW'(j);
      if (!sel_found && pending[j_idx]) begin
        sel_found = 1'b1;
        sel_idx   = j_idx;
      end
    end
  end

  assign take    = (state == SCAN) && sel_found;
  assign ptr_nxt = (int'(sel_idx) == N - 1) ? '0 : AW'(sel_idx + 1'b1);
  assign up_addr = AW'(iUP_INDEX);

  always_comb begin
    clr_mask = '0;
    if (take) clr_mask[sel_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PRIME:   state_nxt = SCAN;
      SCAN:    if (sel_found) state_nxt = PRESENT;
      PRESENT: if (iEV_READY) state_nxt = SCAN;
      default: state_nxt = PRIME;
    endcase
  end

  always_ff @(posedge iMAIN_CLK or negedge iRESET_N) begin
    if (!iRESET_N) state <= PRIME;
    else           state <= state_nxt;
  end

  assign oUP_READY = (state != PRIME);

  always_ff @(posedge iMAIN_CLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      snap       <= '0;
      prev       <= '0;
      pending    <= '0;
      ptr        <= '0;
      oEV_VALID  <= 1'b0;
      oEV_INDEX  <= '0;
      oEV_DATA   <= '0;
      oJTAG_DATA <= '0;
    end else begin
      snap <= iJTAG_DATA;
      // Baseline comes from the same sample snap takes, so whatever was held through reset is not an event.
      if (state == PRIME) prev <= iJTAG_DATA;
      else                prev <= snap;
      // A change detected on the cycle its index is taken keeps pending set, so it is never lost.
      pending <= (pending & ~clr_mask) | changed;
      if (take) begin
        oEV_VALID <= 1'b1;
        oEV_INDEX <= INDEX_WIDTH'(sel_idx);
        oEV_DATA  <= prev[sel_idx];
        ptr       <= ptr_nxt;
      end else if ((state == PRESENT) && iEV_READY) begin
        oEV_VALID <= 1'b0;
      end
      if (iUP_VALID && oUP_READY && (int'(iUP_INDEX) < N)) begin
        oJTAG_DATA[up_addr] <= iUP_DATA;
      end
    end
  end

`ifdef JTAG_SCHED_OVERRUN_EN
  logic [N-1:0] overrun;

  always_ff @(posedge iMAIN_CLK or negedge iRESET_N) begin
    if (!iRESET_N) overrun <= '0;
    else           overrun <= (iOVERRUN_CLR ? '0 : overrun) | (changed & pending);
  end

  assign oOVERRUN = overrun;
`else
  logic unused_overrun_clr;
  assign unused_overrun_clr = iOVERRUN_CLR;
  assign oOVERRUN           = '0;
`endif

endmodule

// File: tb/tb_jtag_access_scheduler.sv
// Scoreboard bench for jtag_access_scheduler: expected events queued at stimulus, compared against
// handshakes captured by a negedge monitor.
module tb_jtag_access_scheduler;

  localparam int N  = 4;
  localparam int RS = 32;
  localparam int IW = 3;

  typedef struct {
    logic [IW-1:0] idx;
    logic [RS-1:0] data;
  } ev_t;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0][RS-1:0] jtag_in;
  logic [N-1:0][RS-1:0] jtag_out;
  logic                 ev_valid, ev_ready;
  logic [IW-1:0]        ev_index;
  logic [RS-1:0]        ev_data;
  logic                 up_valid, up_ready;
  logic [IW-1:0]        up_index;
  logic [RS-1:0]        up_data;
  logic [N-1:0]         overrun;
  logic                 overrun_clr;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  tests_run    = 0;
  int  tests_failed = 0;
  int  valid_cycles = 0;
  int  gap_err      = 0;
  logic last_hs     = 1'b0;

  jtag_access_scheduler #(
    .REGISTER_SIZE(RS),
    .NUMBER_OF_REGISTERS(N),
    .INDEX_WIDTH(IW)
  ) dut (
    .iMAIN_CLK(clk),
    .iRESET_N(rst_n),
    .iJTAG_DATA(jtag_in),
    .oJTAG_DATA(jtag_out),
    .oEV_VALID(ev_valid),
    .iEV_READY(ev_ready),
    .oEV_INDEX(ev_index),
    .oEV_DATA(ev_data),
    .iUP_VALID(up_valid),
    .oUP_READY(up_ready),
    .iUP_INDEX(up_index),
    .iUP_DATA(up_data),
    .oOVERRUN(overrun),
    .iOVERRUN_CLR(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every handshake; flag an event presented right after a handshake (no idle cycle).
  always @(negedge clk) begin
    ev_t o;
    if (rst_n) begin
      if (ev_valid) begin
        valid_cycles++;
        if (last_hs) gap_err++;
      end
      if (ev_valid && ev_ready) begin
        o.idx  = ev_index;
        o.data = ev_data;
        obs_q.push_back(o);
        last_hs = 1'b1;
      end else begin
        last_hs = 1'b0;
      end
    end else begin
      last_hs = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int idx, input logic [RS-1:0] data);
    ev_t e;
    e.idx  = IW'(idx);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_obs(input int n);
    for (int c = 0; c < 60 && obs_q.size() < n; c++) tick(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    jtag_in     = '0;
    jtag_in[2]  = 32'h55;
    ev_ready    = 1'b1;
    up_valid    = 1'b0;
    up_index    = '0;
    up_data     = '0;
    overrun_clr = 1'b0;
    tick(3);
    tests_run++;
    if (ev_valid !== 1'b0 || up_ready !== 1'b0 || jtag_out !== '0 || overrun !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs valid=%b up_ready=%b jtag_out=%h overrun=%b required all 0",
               ev_valid, up_ready, jtag_out, overrun);
    end
    rst_n = 1'b1;
    tick(10);
    tests_run++;
    if (valid_cycles !== 0 || obs_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_event valid_cycles=%0d events=%0d required 0", valid_cycles, obs_q.size());
    end
    tests_run++;
    if (up_ready !== 1'b1 || jtag_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_release up_ready=%b jtag_out=%h required 1 / 0", up_ready, jtag_out);
    end
  endtask

  task automatic test_single();
    ev_t e, o;
    ev_ready   = 1'b1;
    jtag_in[1] = 32'hDEADBEEF;
    expect_ev(1, 32'hDEADBEEF);
    tick(2);
    tests_run++;
    if (ev_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_early valid=%b at t+2 required 0", ev_valid);
    end
    tick(1);
    tests_run++;
    if (ev_valid !== 1'b1 || ev_index !== 3'd1 || ev_data !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL single_latency valid=%b idx=%0d data=%h required 1/1/deadbeef", ev_valid, ev_index, ev_data);
    end
    tick(1);
    tests_run++;
    if (ev_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_one_cycle valid=%b at t+4 required 0", ev_valid);
    end
    wait_obs(1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++;
        $display("FAIL single_missing got none required idx=%0d data=%h", e.idx, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.idx !== e.idx || o.data !== e.data) begin
          tests_failed++;
          $display("FAIL single_event got idx=%0d data=%h required idx=%0d data=%h", o.idx, o.data, e.idx, e.data);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    ev_t e, o;
    int n;
    ev_ready = 1'b1;
    do_reset();
    obs_q.delete();
    gap_err = 0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        jtag_in[0] = 32'hA0A0_0000;
        jtag_in[2] = 32'hA2A2_2222;
        jtag_in[3] = 32'hA3A3_3333;
        expect_ev(0, 32'hA0A0_0000);
        expect_ev(2, 32'hA2A2_2222);
        expect_ev(3, 32'hA3A3_3333);
      end else begin
        jtag_in[0] = 32'hB0B0_0000;
        jtag_in[3] = 32'hB3B3_3333;
        expect_ev(0, 32'hB0B0_0000);
        expect_ev(3, 32'hB3B3_3333);
      end
      n = exp_q.size();
      wait_obs(n);
      tick(4);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (obs_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rr_missing pass=%0d got none required idx=%0d data=%h", pass, e.idx, e.data);
        end else begin
          o = obs_q.pop_front();
          if (o.idx !== e.idx || o.data !== e.data) begin
            tests_failed++;
            $display("FAIL rr_order pass=%0d got idx=%0d data=%h required idx=%0d data=%h",
                     pass, o.idx, o.data, e.idx, e.data);
          end
        end
      end
      tests_run++;
      if (obs_q.size() != 0) begin
        tests_failed++;
        $display("FAIL rr_extra pass=%0d got %0d extra events required 0", pass, obs_q.size());
        obs_q.delete();
      end
    end
    tests_run++;
    if (gap_err !== 0) begin
      tests_failed++;
      $display("FAIL back_to_back_gap got %0d events without idle cycle required 0", gap_err);
    end
  endtask

  task automatic test_coalesce_overrun();
    ev_t e, o;
    logic [N-1:0] exp_ovr;
`ifdef JTAG_SCHED_OVERRUN_EN
    exp_ovr = 4'b0100;
`else
    exp_ovr = 4'b0000;
`endif
    ev_ready   = 1'b0;
    jtag_in[0] = 32'h11;
    expect_ev(0, 32'h11);
    tick(4);
    tests_run++;
    if (ev_valid !== 1'b1 || ev_index !== 3'd0 || ev_data !== 32'h11) begin
      tests_failed++;
      $display("FAIL present_reg0 valid=%b idx=%0d data=%h required 1/0/11", ev_valid, ev_index, ev_data);
    end
    jtag_in[2] = 32'h1;
    tick(1);
    jtag_in[2] = 32'h2;
    expect_ev(2, 32'h2);
    tick(5);
    tests_run++;
    if (ev_valid !== 1'b1 || ev_index !== 3'd0 || ev_data !== 32'h11) begin
      tests_failed++;
      $display("FAIL present_stable valid=%b idx=%0d data=%h required 1/0/11", ev_valid, ev_index, ev_data);
    end
    tests_run++;
    if (overrun !== exp_ovr) begin
      tests_failed++;
      $display("FAIL overrun_set got %b required %b", overrun, exp_ovr);
    end
    ev_ready = 1'b1;
    wait_obs(2);
    tick(6);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++;
        $display("FAIL coalesce_missing got none required idx=%0d data=%h", e.idx, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.idx !== e.idx || o.data !== e.data) begin
          tests_failed++;
          $display("FAIL coalesce_event got idx=%0d data=%h required idx=%0d data=%h", o.idx, o.data, e.idx, e.data);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL coalesce_extra got %0d extra events required 0", obs_q.size());
      obs_q.delete();
    end
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    tick(1);
    tests_run++;
    if (overrun !== 4'b0000) begin
      tests_failed++;
      $display("FAIL overrun_clear got %b required 0000", overrun);
    end
  endtask

  task automatic test_readback();
    logic [N-1:0][RS-1:0] exp_rb;
    exp_rb = '0;
    tests_run++;
    if (up_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL up_ready got %b required 1", up_ready);
    end
    up_valid = 1'b1;
    up_index = 3'd1;
    up_data  = 32'hA5;
    exp_rb[1] = 32'hA5;
    tick(1);
    up_valid = 1'b0;
    tests_run++;
    if (jtag_out !== exp_rb) begin
      tests_failed++;
      $display("FAIL readback_write got %h required %h", jtag_out, exp_rb);
    end
    up_valid = 1'b1;
    up_index = 3'd4;
    up_data  = 32'hFFFF_FFFF;
    tick(1);
    up_valid = 1'b0;
    tick(1);
    tests_run++;
    if (jtag_out !== exp_rb) begin
      tests_failed++;
      $display("FAIL readback_discard got %h required %h", jtag_out, exp_rb);
    end
  endtask

  task automatic test_reset_midflight();
    int vc;
    ev_ready   = 1'b0;
    jtag_in[3] = 32'h77;
    for (int c = 0; c < 10 && !ev_valid; c++) tick(1);
    tests_run++;
    if (ev_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL midflight_present valid=%b required 1", ev_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (ev_valid !== 1'b0 || jtag_out !== '0) begin
      tests_failed++;
      $display("FAIL async_reset valid=%b jtag_out=%h required 0 without clock edge", ev_valid, jtag_out);
    end
    ev_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    vc = valid_cycles;
    tick(10);
    tests_run++;
    if (valid_cycles !== vc || obs_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL midflight_replay got %0d valid cycles %0d events required 0", valid_cycles - vc, obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_coalesce_overrun();
    test_readback();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
